// File: rtl/cpu_controller.sv
// Moore sequencer for the simple-RISC datapath: one instruction per start pulse,
// decoder register select, datapath strobes and a retired-instruction counter.
module cpu_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [1:0]       ALU_op,
    output logic             waiting,
    output logic [1:0]       reg_sel,
    output logic             load_a,
    output logic             load_b,
    output logic             asel,
    output logic             load_c,
    output logic             load_s,
    output logic [1:0]       wb_sel,
    output logic             w_en,
    output logic             bad_instr,
    output logic [CNT_W-1:0] n_retired
);

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_WR_IMM = 3'd2;
    localparam logic [2:0] S_LD_A   = 3'd3;
    localparam logic [2:0] S_LD_B   = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_WR_REG = 3'd6;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [4:0] op;
    logic       is_movi, is_movr, is_mvn, is_add, is_cmp, is_and;
    logic       retire;

    // Sequencing uses only the op captured at start; later IR changes are ignored.
    assign is_movi = (op == 5'b110_10);
    assign is_movr = (op == 5'b110_00);
    assign is_mvn  = (op == 5'b101_11);
    assign is_add  = (op == 5'b101_00);
    assign is_cmp  = (op == 5'b101_01);
    assign is_and  = (op == 5'b101_10);

    assign retire = (state == S_WR_IMM) || (state == S_WR_REG) ||
                    ((state == S_EXEC) && is_cmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT;
            op        <= '0;
            n_retired <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_WAIT) && start)
                op <= {opcode, ALU_op};
            if (retire)
                n_retired <= n_retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:   if (start) state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_movi)
                    state_nxt = S_WR_IMM;
                else if (is_movr || is_mvn)
                    state_nxt = S_LD_B;
                else if (is_add || is_cmp || is_and)
                    state_nxt = S_LD_A;
                else
                    state_nxt = S_WAIT;
            end
            S_WR_IMM: state_nxt = S_WAIT;
            S_LD_A:   state_nxt = S_LD_B;
            S_LD_B:   state_nxt = S_EXEC;
            S_EXEC:   state_nxt = is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: state_nxt = S_WAIT;
            default:  state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        waiting   = 1'b0;
        reg_sel   = 2'b00;
        load_a    = 1'b0;
        load_b    = 1'b0;
        asel      = 1'b0;
        load_c    = 1'b0;
        load_s    = 1'b0;
        wb_sel    = 2'b00;
        w_en      = 1'b0;
        bad_instr = 1'b0;
        case (state)
            S_WAIT:   waiting = 1'b1;
            S_DECODE: bad_instr = !(is_movi || is_movr || is_mvn ||
                                    is_add || is_cmp || is_and);
            S_WR_IMM: begin
                reg_sel = 2'b10;
                wb_sel  = 2'b01;
                w_en    = 1'b1;
            end
            S_LD_A: begin
                reg_sel = 2'b10;
                load_a  = 1'b1;
            end
            S_LD_B:   load_b = 1'b1;
            S_EXEC: begin
                asel   = is_movr || is_mvn;
                load_c = !is_cmp;
                load_s = (op[4:2] == 3'b101);
            end
            S_WR_REG: begin
                reg_sel = 2'b01;
                w_en    = 1'b1;
            end
            default:  waiting = 1'b1;
        endcase
    end

endmodule
